// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and sizing helper for the UART transmit path
package uart_pkg;

  localparam int DEFAULT_WORD_SIZE    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    TX_IDLE   = ST_IDLE,
    TX_START  = ST_START,
    TX_DATA   = ST_DATA,
    TX_PARITY = ST_PARITY,
    TX_STOP   = ST_STOP
  } tx_state_e;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int logb2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - start/buffer handshake and UART line outputs of the transmit framer
interface uart_tx_framer_if;

  logic start_en;
  logic buf_empty;
  logic buf_serial_data;
  logic buf_rd_enable;
  logic tx;
  logic busy;
  logic done;
  logic underrun;

  modport master (
    output start_en, buf_empty, buf_serial_data,
    input  buf_rd_enable, tx, busy, done, underrun
  );

  modport slave (
    input  start_en, buf_empty, buf_serial_data,
    output buf_rd_enable, tx, busy, done, underrun
  );

endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - per-bit cycle counter with bit-end and fetch-lookahead strobes
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CW           = logb2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_end,
  output logic fetch_next
);

  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FETCH = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] cyc_nxt;

  always_comb begin
    cyc_nxt = '0;
    if (run && !clear && cyc_cnt != LAST) cyc_nxt = cyc_cnt + CW'(1);
  end

  assign bit_end = run && (cyc_cnt == LAST);
  // Flags the cycle before the fetch slot so the owner can register its read strobe.
  assign fetch_next = (cyc_nxt == FETCH);

  always_ff @(posedge clk) begin
    if (!reset) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_nxt;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer pulling LSB-first data bits from tx_buffer
// Wraps each word in start/optional parity/stop bits; frames run back-to-back while data remains.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_framer_if.slave  bus
);

  localparam int CW = logb2(CLKS_PER_BIT);
  localparam int BW = logb2(WORD_SIZE);
  localparam logic [BW-1:0] LAST_DATA = BW'(WORD_SIZE - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = 1'(PARITY_ODD);

  tx_state_e      state, state_nxt;
  logic [BW-1:0]  bit_cnt, bit_nxt;
  logic           parity_acc, parity_nxt;
  logic           tx_nxt, rd_nxt, done_nxt;
  logic           bit_end, fetch_next;
  logic           frame_go, start_frame;

  assign frame_go    = bus.start_en && !bus.buf_empty;
  assign start_frame = (state == TX_IDLE) && frame_go;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_frame),
    .run        (state != TX_IDLE),
    .bit_end    (bit_end),
    .fetch_next (fetch_next)
  );

  always_comb begin
    state_nxt  = state;
    bit_nxt    = bit_cnt;
    parity_nxt = parity_acc;
    tx_nxt     = bus.tx;
    done_nxt   = 1'b0;
    unique case (state)
      TX_IDLE: begin
        tx_nxt = 1'b1;
        if (frame_go) begin
          state_nxt  = TX_START;
          tx_nxt     = 1'b0;
          parity_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_nxt  = TX_DATA;
          bit_nxt    = '0;
          tx_nxt     = bus.buf_serial_data;
          parity_nxt = parity_acc ^ bus.buf_serial_data;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            bit_nxt = '0;
            if (PARITY_EN != 0) begin
              state_nxt = TX_PARITY;
              tx_nxt    = parity_acc ^ ODD;
            end else begin
              state_nxt = TX_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt    = bit_cnt + BW'(1);
            tx_nxt     = bus.buf_serial_data;
            parity_nxt = parity_acc ^ bus.buf_serial_data;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_nxt = TX_STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            done_nxt = 1'b1;
            bit_nxt  = '0;
            // Chain straight into the next start bit when more data is waiting.
            if (frame_go) begin
              state_nxt  = TX_START;
              tx_nxt     = 1'b0;
              parity_nxt = 1'b0;
            end else begin
              state_nxt = TX_IDLE;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_nxt = TX_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
    // The strobe lands in the fetch slot of the state we are entering, one cycle ahead of the data use.
    rd_nxt = fetch_next &&
             ((state_nxt == TX_START) || ((state_nxt == TX_DATA) && (bit_nxt < LAST_DATA)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= TX_IDLE;
      bit_cnt           <= '0;
      parity_acc        <= 1'b0;
      bus.tx            <= 1'b1;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.buf_rd_enable <= 1'b0;
      bus.underrun      <= 1'b0;
    end else begin
      state             <= state_nxt;
      bit_cnt           <= bit_nxt;
      parity_acc        <= parity_nxt;
      bus.tx            <= tx_nxt;
      bus.busy          <= (state_nxt != TX_IDLE);
      bus.done          <= done_nxt;
      bus.buf_rd_enable <= rd_nxt;
      bus.underrun      <= bus.buf_rd_enable && bus.buf_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer against a frame-level line model
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int NI  = 4;
  // Instance variants: 0 plain, 1 even parity, 2 odd parity, 3 two stop bits.
  localparam logic [NI-1:0] PE_V  = 4'b0110;
  localparam logic [NI-1:0] ODD_V = 4'b0100;
  localparam logic [NI-1:0] SB2_V = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_en = 1'b0;
  always #5 clk = ~clk;

  logic        load_req    [NI];
  logic [63:0] load_bits   [NI];
  int          load_n      [NI];
  logic        force_empty [NI];

  logic tx_w [NI];
  logic busy_w [NI];
  logic done_w [NI];
  logic rd_w [NI];
  int   rd_cnt_w [NI];
  int   und_cnt_w [NI];
  int   done_cnt_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_framer_if bus();
    logic [63:0] bits = '0;
    int          nbits = 0;
    logic        sd = 1'b0;
    int          rd_cnt = 0;
    int          und_cnt = 0;
    int          done_cnt = 0;

    assign bus.start_en        = start_en;
    assign bus.buf_empty       = (nbits == 0) || force_empty[g];
    assign bus.buf_serial_data = sd;

    uart_tx_framer #(
      .WORD_SIZE    (W),
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    (PE_V[g] ? 1 : 0),
      .PARITY_ODD   (ODD_V[g] ? 1 : 0),
      .STOP_BITS    (SB2_V[g] ? 2 : 1)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    // tx_buffer stand-in: a read strobe presents the next LSB on the following cycle.
    always @(posedge clk) begin
      if (bus.buf_rd_enable) rd_cnt <= rd_cnt + 1;
      if (bus.underrun) und_cnt <= und_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (load_req[g]) begin
        bits  <= load_bits[g];
        nbits <= load_n[g];
      end else if (bus.buf_rd_enable && !bus.buf_empty) begin
        sd    <= bits[0];
        bits  <= bits >> 1;
        nbits <= nbits - 1;
      end
    end

    assign tx_w[g]       = bus.tx;
    assign busy_w[g]     = bus.busy;
    assign done_w[g]     = bus.done;
    assign rd_w[g]       = bus.buf_rd_enable;
    assign rd_cnt_w[g]   = rd_cnt;
    assign und_cnt_w[g]  = und_cnt;
    assign done_cnt_w[g] = done_cnt;
  end

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int g, input logic [63:0] b, input int n);
    load_bits[g] = b;
    load_n[g]    = n;
    load_req[g]  = 1'b1;
    step(1);
    load_req[g]  = 1'b0;
  endtask

  // Expected line: per word a 0 start bit, LSB-first data, optional parity, stop 1s.
  task automatic run_frames(input int g, input logic [63:0] data, input int nw, input string tag);
    logic line[$];
    logic [7:0] word;
    int pe, sb, fl, total, r0, u0, d0;
    pe = PE_V[g] ? 1 : 0;
    sb = SB2_V[g] ? 2 : 1;
    fl = (1 + W + pe + sb) * CPB;
    line = {};
    for (int w = 0; w < nw; w++) begin
      word = 8'(data >> (8 * w));
      line.push_back(1'b0);
      for (int i = 0; i < W; i++) line.push_back(word[i]);
      if (pe != 0) line.push_back((^word) ^ ODD_V[g]);
      for (int i = 0; i < sb; i++) line.push_back(1'b1);
    end
    total = line.size() * CPB;
    load(g, data, W * nw);
    r0 = rd_cnt_w[g];
    u0 = und_cnt_w[g];
    d0 = done_cnt_w[g];
    start_en = 1'b1;
    for (int c = 0; c <= total; c++) begin
      step(1);
      if (c < total) begin
        chk({tag, " tx"}, 32'(tx_w[g]), 32'(line[c / CPB]));
        chk({tag, " busy"}, 32'(busy_w[g]), 32'd1);
      end else begin
        chk({tag, " idle tx"}, 32'(tx_w[g]), 32'd1);
        chk({tag, " idle busy"}, 32'(busy_w[g]), 32'd0);
      end
      chk({tag, " done"}, 32'(done_w[g]), 32'((c > 0) && (c % fl == 0)));
    end
    start_en = 1'b0;
    step(1);
    chk({tag, " strobes"}, 32'(rd_cnt_w[g] - r0), 32'(W * nw));
    chk({tag, " dones"}, 32'(done_cnt_w[g] - d0), 32'(nw));
    chk({tag, " underruns"}, 32'(und_cnt_w[g] - u0), 32'd0);
  endtask

  int r0, u0;
  logic [63:0] rdata;
  int rnw;

  initial begin
    for (int g = 0; g < NI; g++) begin
      load_req[g]    = 1'b0;
      load_bits[g]   = '0;
      load_n[g]      = 0;
      force_empty[g] = 1'b0;
    end

    step(2);
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      chk("reset tx", 32'(tx_w[g]), 32'd1);
      chk("reset busy", 32'(busy_w[g]), 32'd0);
      chk("reset done", 32'(done_w[g]), 32'd0);
      chk("reset rd", 32'(rd_w[g]), 32'd0);
    end

    run_frames(0, 64'hA5, 1, "a5");
    run_frames(1, 64'h07, 1, "even07");
    run_frames(2, 64'h07, 1, "odd07");
    run_frames(0, 64'h813C, 2, "b2b");
    run_frames(3, 64'hC96E, 2, "stop2");

    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < NI; g++) begin
        rnw   = $urandom_range(1, 3);
        rdata = {$urandom, $urandom};
        run_frames(g, rdata, rnw, "rand");
      end
    end

    // Enabled but empty: nothing may start.
    r0 = rd_cnt_w[1];
    start_en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (c % 10 == 9) begin
        chk("empty tx", 32'(tx_w[1]), 32'd1);
        chk("empty busy", 32'(busy_w[1]), 32'd0);
      end
    end
    chk("empty strobes", 32'(rd_cnt_w[1] - r0), 32'd0);
    start_en = 1'b0;

    // Buffer forced empty after three fetches: five underruns, length unchanged.
    load(0, 64'h5A, W);
    r0 = rd_cnt_w[0];
    u0 = und_cnt_w[0];
    start_en = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      step(1);
      if (c == 12) force_empty[0] = 1'b1;
      chk("force busy", 32'(busy_w[0]), 32'(c < 40));
      chk("force done", 32'(done_w[0]), 32'(c == 40));
    end
    start_en = 1'b0;
    step(1);
    chk("force underruns", 32'(und_cnt_w[0] - u0), 32'd5);
    chk("force strobes", 32'(rd_cnt_w[0] - r0), 32'(W));
    load(0, 64'h0, 0);
    force_empty[0] = 1'b0;

    // Reset during data bit 3, held two cycles.
    load(2, 64'hC3, W);
    start_en = 1'b1;
    step(17);
    reset = 1'b0;
    start_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(1);
      chk("abort tx", 32'(tx_w[2]), 32'd1);
      chk("abort busy", 32'(busy_w[2]), 32'd0);
      chk("abort rd", 32'(rd_w[2]), 32'd0);
      chk("abort done", 32'(done_w[2]), 32'd0);
    end
    reset = 1'b1;
    r0 = rd_cnt_w[2];
    step(10);
    chk("post-abort strobes", 32'(rd_cnt_w[2] - r0), 32'd0);
    chk("post-abort tx", 32'(tx_w[2]), 32'd1);
    run_frames(2, 64'h3B, 1, "fresh");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
